// File: rtl/oam_dma_gen.sv
// Sprite/OAM DMA engine: copies LEN bytes from a latched source page to one fixed
// destination, alternating read/write cycles, with CPU RDY control and DMC arbitration.
module oam_dma_gen #(
  parameter int          LEN       = 256,
  parameter logic [7:0]  START_LO  = 8'h00,
  parameter logic [15:0] DST_ADDR  = 16'h2004,
  parameter bit          ALIGN_ODD = 1'b1
) (
  input  logic        ACLK,
  input  logic        RES,
  input  logic        W4014,
  input  logic [7:0]  DB_in,
  input  logic        CPU_RnW,
  input  logic [15:0] CPU_Addr,
  input  logic        DMC_REQ,
  input  logic [15:0] DMC_Addr,
  input  logic        DMCRDY,
  output logic [15:0] Addr,
  output logic        RnW_out,
  output logic [7:0]  DB_out,
  output logic        DB_oe,
  output logic        DMC_GNT,
  output logic        RDY,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  localparam logic [7:0] LAST = 8'(LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] page;
  logic [7:0] dbuf;
  logic       parity;
  logic [7:0] rd_lo;

  // Low byte wraps within the page; the page itself never increments.
  assign rd_lo = START_LO + cnt;

  always_ff @(posedge ACLK or posedge RES) begin
    if (RES) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      page   <= 8'd0;
      dbuf   <= 8'd0;
      parity <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_nxt;
      parity <= ~parity;
      DONE   <= (state == WRITE) && (cnt == LAST);
      case (state)
        IDLE: begin
          if (W4014) begin
            page <= DB_in;
            cnt  <= 8'd0;
          end
        end
        READ: begin
          if (!DMC_GNT) dbuf <= DB_in;
        end
        WRITE: begin
          cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (W4014) state_nxt = HALT;
      HALT: begin
        if (CPU_RnW) state_nxt = (ALIGN_ODD && parity) ? ALIGN : READ;
      end
      ALIGN: state_nxt = READ;
      READ:  if (!DMC_GNT) state_nxt = WRITE;
      WRITE: state_nxt = (cnt == LAST) ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  // A WRITE is never pre-empted; the DMC takes the following READ slot instead.
  assign DMC_GNT = DMC_REQ && (state != WRITE);

  always_comb begin
    Addr = CPU_Addr;
    if (DMC_GNT)             Addr = DMC_Addr;
    else if (state == READ)  Addr = {page, rd_lo};
    else if (state == WRITE) Addr = DST_ADDR;
  end

  assign RnW_out = ~((state == WRITE) && !DMC_GNT);
  assign DB_oe   = (state == WRITE);
  assign DB_out  = dbuf;
  assign RDY     = (state == IDLE) && DMCRDY;
  assign BUSY    = (state != IDLE);

endmodule
